// File: rtl/memory_access_stage_if.sv
// Data-memory bus between the memory access stage (master) and the memory (slave).
// The request side is registered in the master. Ack is a one-cycle pulse, with rdata valid in the same cycle.
interface memory_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM stage: issues loads/stores from EX/MEM on the req/ack data bus, stalls earlier stages
// while an access is pending, formats load data and registers the result into MEM/WB.
module memory_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           alu_out_ex_mem_i,
  input  logic [31:0]           rs2_ex_mem_i,
  input  logic [4:0]            rd_ex_mem_i,
  input  logic [1:0]            wb_sel_ex_mem_i,
  input  logic [2:0]            funct3_ex_mem_i,
  input  logic                  is_load_instr_ex_mem_i,
  input  logic                  is_store_instr_ex_mem_i,
  memory_access_stage_if.master mem_bus,
  output logic                  busywait_o,
  output logic [4:0]            rd_mem_wb_o,
  output logic [31:0]           alu_out_mem_wb_o,
  output logic [31:0]           rd_data_mem_wb_o,
  output logic [1:0]            wb_sel_mem_wb_o,
  output logic                  is_load_instr_mem_wb_o,
  output logic                  misaligned_o,
  output logic                  bus_error_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_lat_q, rd_lat_d;
  logic [1:0]  wbsel_lat_q, wbsel_lat_d;
  logic [31:0] alu_lat_q, alu_lat_d;
  logic        ld_lat_q, ld_lat_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic        wb_ld_q, wb_ld_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;
  logic        busy_s;
  logic        access_s;
  logic        misaligned_s;
  logic [3:0]  st_be_s;
  logic [31:0] st_wdata_s;

  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b100:  format_load = {24'h000000, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b101:  format_load = {16'h0000, h};
      default: format_load = word;
    endcase
  endfunction

  assign access_s     = is_load_instr_ex_mem_i | is_store_instr_ex_mem_i;
  assign misaligned_s = ((funct3_ex_mem_i[1:0] == 2'b01) & alu_out_ex_mem_i[0]) |
                        ((funct3_ex_mem_i == 3'b010) & (alu_out_ex_mem_i[1:0] != 2'b00));

  // Store lane placement: narrow data is replicated so any enabled lane carries it.
  always_comb begin
    st_be_s    = 4'b1111;
    st_wdata_s = rs2_ex_mem_i;
    case (funct3_ex_mem_i[1:0])
      2'b00: begin
        st_be_s    = 4'b0001 << alu_out_ex_mem_i[1:0];
        st_wdata_s = {4{rs2_ex_mem_i[7:0]}};
      end
      2'b01: begin
        st_be_s    = 4'b0011 << alu_out_ex_mem_i[1:0];
        st_wdata_s = {2{rs2_ex_mem_i[15:0]}};
      end
      default: begin
        st_be_s    = 4'b1111;
        st_wdata_s = rs2_ex_mem_i;
      end
    endcase
  end

  // Access FSM next-state, stall and MEM/WB next values; bubble is the default.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rd_lat_d    = rd_lat_q;
    wbsel_lat_d = wbsel_lat_q;
    alu_lat_d   = alu_lat_q;
    ld_lat_d    = ld_lat_q;
    wb_rd_d     = 5'd0;
    wb_alu_d    = wb_alu_q;
    wb_data_d   = wb_data_q;
    wb_sel_d    = wb_sel_q;
    wb_ld_d     = 1'b0;
    mis_d       = 1'b0;
    berr_d      = 1'b0;
    busy_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_s) begin
          if (misaligned_s) begin
            mis_d = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            cnt_d       = '0;
            req_d       = 1'b1;
            we_d        = is_store_instr_ex_mem_i;
            be_d        = st_be_s;
            wdata_d     = st_wdata_s;
            f3_d        = funct3_ex_mem_i;
            rd_lat_d    = rd_ex_mem_i;
            wbsel_lat_d = wb_sel_ex_mem_i;
            alu_lat_d   = alu_out_ex_mem_i;
            ld_lat_d    = is_load_instr_ex_mem_i;
            busy_s      = 1'b1;
          end
        end else begin
          wb_rd_d   = rd_ex_mem_i;
          wb_alu_d  = alu_out_ex_mem_i;
          wb_data_d = 32'h0000_0000;
          wb_sel_d  = wb_sel_ex_mem_i;
          wb_ld_d   = 1'b0;
        end
      end
      ST_ACCESS: begin
        if (mem_bus.mem_ack) begin
          state_d   = ST_IDLE;
          req_d     = 1'b0;
          cnt_d     = '0;
          wb_rd_d   = rd_lat_q;
          wb_alu_d  = alu_lat_q;
          wb_data_d = format_load(f3_q, alu_lat_q[1:0], mem_bus.mem_rdata);
          wb_sel_d  = wbsel_lat_q;
          wb_ld_d   = ld_lat_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
          cnt_d   = '0;
          berr_d  = 1'b1;
        end else begin
          busy_s = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State, bus request and MEM/WB registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'h0000_0000;
      f3_q        <= 3'b000;
      rd_lat_q    <= 5'd0;
      wbsel_lat_q <= 2'b00;
      alu_lat_q   <= 32'h0000_0000;
      ld_lat_q    <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_alu_q    <= 32'h0000_0000;
      wb_data_q   <= 32'h0000_0000;
      wb_sel_q    <= 2'b00;
      wb_ld_q     <= 1'b0;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      rd_lat_q    <= rd_lat_d;
      wbsel_lat_q <= wbsel_lat_d;
      alu_lat_q   <= alu_lat_d;
      ld_lat_q    <= ld_lat_d;
      wb_rd_q     <= wb_rd_d;
      wb_alu_q    <= wb_alu_d;
      wb_data_q   <= wb_data_d;
      wb_sel_q    <= wb_sel_d;
      wb_ld_q     <= wb_ld_d;
      mis_q       <= mis_d;
      berr_q      <= berr_d;
    end
  end

  assign mem_bus.mem_req   = req_q;
  assign mem_bus.mem_we    = we_q;
  assign mem_bus.mem_addr  = alu_lat_q[31:2];
  assign mem_bus.mem_be    = be_q;
  assign mem_bus.mem_wdata = wdata_q;

  assign busywait_o             = busy_s;
  assign rd_mem_wb_o            = wb_rd_q;
  assign alu_out_mem_wb_o       = wb_alu_q;
  assign rd_data_mem_wb_o       = wb_data_q;
  assign wb_sel_mem_wb_o        = wb_sel_q;
  assign is_load_instr_mem_wb_o = wb_ld_q;
  assign misaligned_o           = mis_q;
  assign bus_error_o            = berr_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: expected MEM/WB results are queued as
// instructions are issued and popped when the stage writes them back.
module tb_memory_access_stage;

  localparam int unsigned TO = 8;
  localparam int OUT_W = 143;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] data;
    logic [1:0]  wbsel;
    logic        ld;
  } wb_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] alu_out_ex_mem_i = 32'h0;
  logic [31:0] rs2_ex_mem_i = 32'h0;
  logic [4:0]  rd_ex_mem_i = 5'd0;
  logic [1:0]  wb_sel_ex_mem_i = 2'b00;
  logic [2:0]  funct3_ex_mem_i = 3'b000;
  logic        is_load_instr_ex_mem_i = 1'b0;
  logic        is_store_instr_ex_mem_i = 1'b0;
  logic        busywait_o;
  logic [4:0]  rd_mem_wb_o;
  logic [31:0] alu_out_mem_wb_o;
  logic [31:0] rd_data_mem_wb_o;
  logic [1:0]  wb_sel_mem_wb_o;
  logic        is_load_instr_mem_wb_o;
  logic        misaligned_o;
  logic        bus_error_o;

  memory_access_stage_if bus ();

  memory_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i                  (clk_i),
    .rst_i                  (rst_i),
    .alu_out_ex_mem_i       (alu_out_ex_mem_i),
    .rs2_ex_mem_i           (rs2_ex_mem_i),
    .rd_ex_mem_i            (rd_ex_mem_i),
    .wb_sel_ex_mem_i        (wb_sel_ex_mem_i),
    .funct3_ex_mem_i        (funct3_ex_mem_i),
    .is_load_instr_ex_mem_i (is_load_instr_ex_mem_i),
    .is_store_instr_ex_mem_i(is_store_instr_ex_mem_i),
    .mem_bus                (bus),
    .busywait_o             (busywait_o),
    .rd_mem_wb_o            (rd_mem_wb_o),
    .alu_out_mem_wb_o       (alu_out_mem_wb_o),
    .rd_data_mem_wb_o       (rd_data_mem_wb_o),
    .wb_sel_mem_wb_o        (wb_sel_mem_wb_o),
    .is_load_instr_mem_wb_o (is_load_instr_mem_wb_o),
    .misaligned_o           (misaligned_o),
    .bus_error_o            (bus_error_o)
  );

  always #5 clk_i = ~clk_i;

  int  total = 0;
  int  bad = 0;
  wb_t exp_q[$];

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic wb_t cur_wb();
    return {rd_mem_wb_o, alu_out_mem_wb_o, rd_data_mem_wb_o, wb_sel_mem_wb_o, is_load_instr_mem_wb_o};
  endfunction

  function automatic wb_t pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  function automatic logic [OUT_W-1:0] all_outs();
    return {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, busywait_o,
            rd_mem_wb_o, alu_out_mem_wb_o, rd_data_mem_wb_o, wb_sel_mem_wb_o,
            is_load_instr_mem_wb_o, misaligned_o, bus_error_o};
  endfunction

  task automatic drive_instr(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] rs2,
                             input logic [4:0] rd, input logic [1:0] ws);
    is_load_instr_ex_mem_i  = ld;
    is_store_instr_ex_mem_i = st;
    funct3_ex_mem_i         = f3;
    alu_out_ex_mem_i        = addr;
    rs2_ex_mem_i            = rs2;
    rd_ex_mem_i             = rd;
    wb_sel_ex_mem_i         = ws;
  endtask

  task automatic drive_nop();
    drive_instr(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 2'b00);
  endtask

  // Issue one memory instruction at the current slot (posedge+1) and act as the memory:
  // ack after ack_after non-ack ACCESS cycles. Returns stall/req counts, the request seen
  // on the bus and the MEM/WB contents after the ack edge.
  task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [4:0] rd, input logic [1:0] ws,
                            input int ack_after, input logic [31:0] rdata,
                            output int busy_n, output int wait_n,
                            output logic we, output logic [29:0] maddr,
                            output logic [3:0] be, output logic [31:0] wdata,
                            output wb_t wb);
    bit done = 1'b0;
    busy_n = 0;
    wait_n = 0;
    we = 1'b0; maddr = 30'h0; be = 4'h0; wdata = 32'h0;
    drive_instr(ld, st, f3, addr, rs2, rd, ws);
    #1;
    if (busywait_o) busy_n++;
    for (int c = 0; c < 100 && !done; c++) begin
      @(posedge clk_i); #1;
      if (!bus.mem_req) break;
      we = bus.mem_we; maddr = bus.mem_addr; be = bus.mem_be; wdata = bus.mem_wdata;
      if (wait_n == ack_after) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
      #1;
      if (busywait_o) busy_n++;
      if (bus.mem_ack) done = 1'b1;
      else wait_n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL access_handshake addr=%h no ack delivered within bound (req=%b)", addr, bus.mem_req);
    end
    @(posedge clk_i); #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    wb = cur_wb();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    #3;
    total++;
    if (all_outs() !== {OUT_W{1'b0}}) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", all_outs());
    end
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_lw_wait();
    int busy_n, wait_n; logic we; logic [29:0] ma; logic [3:0] be; logic [31:0] wd; wb_t wb, e;
    exp_q.push_back('{rd: 5'd5, alu: 32'h100, data: 32'hDEADBEEF, wbsel: 2'b01, ld: 1'b1});
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 2'b01, 3, 32'hDEADBEEF,
               busy_n, wait_n, we, ma, be, wd, wb);
    drive_nop();
    total++;
    if (busy_n !== 4) begin bad++; $display("FAIL lw_busywait_cycles got=%0d want=4", busy_n); end
    total++;
    if (wait_n !== 3) begin bad++; $display("FAIL lw_req_wait_cycles got=%0d want=3", wait_n); end
    total++;
    if ({we, ma, be} !== {1'b0, 30'h40, 4'hF}) begin
      bad++; $display("FAIL lw_request got=%b/%h/%b want=0/40/1111", we, ma, be);
    end
    e = pop_exp();
    total++;
    if (wb !== e) begin bad++; $display("FAIL lw_writeback got=%h want=%h", wb, e); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_load_format();
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b011};
    logic [31:0] adr [5] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h104};
    logic [31:0] res [5] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFFFF7F, 32'h80FFFF7F};
    int busy_n, wait_n; logic we; logic [29:0] ma; logic [3:0] be; logic [31:0] wd; wb_t wb, e;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{rd: 5'(i + 10), alu: adr[i], data: res[i], wbsel: 2'b01, ld: 1'b1});
      run_access(1'b1, 1'b0, f3s[i], adr[i], 32'h0, 5'(i + 10), 2'b01, 0, 32'h80FFFF7F,
                 busy_n, wait_n, we, ma, be, wd, wb);
      e = pop_exp();
      total++;
      if (wb !== e) begin bad++; $display("FAIL load_format_%0d got=%h want=%h", i, wb, e); end
      total++;
      if (busy_n !== 1 || ma !== adr[i][31:2]) begin
        bad++; $display("FAIL load_stall_%0d busy=%0d addr=%h want busy=1 addr=%h", i, busy_n, ma, adr[i][31:2]);
      end
    end
    drive_nop();
    @(posedge clk_i); #1;
    total++;
    if (bus.mem_req !== 1'b0 || rd_mem_wb_o !== 5'd0) begin
      bad++; $display("FAIL no_reissue req=%b rd=%0d want req=0 rd=0", bus.mem_req, rd_mem_wb_o);
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] adr [3] = '{32'h201, 32'h202, 32'h204};
    logic [3:0]  ebe [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] ewd [3] = '{32'h78787878, 32'h56785678, 32'h12345678};
    int busy_n, wait_n; logic we; logic [29:0] ma; logic [3:0] be; logic [31:0] wd; wb_t wb, e;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{rd: 5'd0, alu: adr[i], data: 32'h0, wbsel: 2'b00, ld: 1'b0});
      run_access(1'b0, 1'b1, f3s[i], adr[i], 32'h12345678, 5'd0, 2'b00, 1, 32'h0,
                 busy_n, wait_n, we, ma, be, wd, wb);
      total++;
      if ({we, ma, be, wd} !== {1'b1, adr[i][31:2], ebe[i], ewd[i]}) begin
        bad++; $display("FAIL store_bus_%0d got we=%b addr=%h be=%b wdata=%h want we=1 addr=%h be=%b wdata=%h",
                        i, we, ma, be, wd, adr[i][31:2], ebe[i], ewd[i]);
      end
      e = pop_exp();
      total++;
      if (wb !== e) begin bad++; $display("FAIL store_writeback_%0d got=%h want=%h", i, wb, e); end
    end
    drive_nop();
    @(posedge clk_i); #1;
  endtask

  task automatic test_non_memory();
    wb_t e;
    drive_instr(1'b0, 1'b0, 3'b000, 32'h5A, 32'h0, 5'd9, 2'b10);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFFFFFF;
    exp_q.push_back('{rd: 5'd9, alu: 32'h5A, data: 32'h0, wbsel: 2'b10, ld: 1'b0});
    #1;
    total++;
    if (busywait_o !== 1'b0) begin bad++; $display("FAIL alu_no_stall got=%b want=0", busywait_o); end
    @(posedge clk_i); #1;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    e = pop_exp();
    total++;
    if (cur_wb() !== e || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL alu_passthrough got=%h req=%b want=%h req=0", cur_wb(), bus.mem_req, e);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3s [2] = '{3'b010, 3'b101};
    logic [31:0] adr [2] = '{32'h102, 32'h203};
    for (int i = 0; i < 2; i++) begin
      drive_instr(i == 0, i == 1, f3s[i], adr[i], 32'hA5A5A5A5, 5'd7, 2'b01);
      #1;
      total++;
      if (busywait_o !== 1'b0) begin bad++; $display("FAIL misaligned_stall_%0d got=%b want=0", i, busywait_o); end
      @(posedge clk_i); #1;
      drive_instr(1'b0, 1'b0, 3'b000, 32'h77, 32'h0, 5'd9, 2'b10);
      total++;
      if ({misaligned_o, bus.mem_req, rd_mem_wb_o, is_load_instr_mem_wb_o} !== {1'b1, 1'b0, 5'd0, 1'b0}) begin
        bad++; $display("FAIL misaligned_%0d got mis=%b req=%b rd=%0d want mis=1 req=0 rd=0",
                        i, misaligned_o, bus.mem_req, rd_mem_wb_o);
      end
      @(posedge clk_i); #1;
      total++;
      if (misaligned_o !== 1'b0 || rd_mem_wb_o !== 5'd9) begin
        bad++; $display("FAIL misaligned_pulse_%0d got mis=%b rd=%0d want mis=0 rd=9", i, misaligned_o, rd_mem_wb_o);
      end
    end
    drive_nop();
    @(posedge clk_i); #1;
  endtask

  task automatic test_timeout();
    drive_instr(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 5'd4, 2'b01);
    for (int k = 1; k <= int'(TO); k++) begin
      @(posedge clk_i); #1;
      total++;
      if (bus.mem_req !== 1'b1 || busywait_o !== (k < int'(TO))) begin
        bad++; $display("FAIL timeout_cycle_%0d req=%b busy=%b want req=1 busy=%b",
                        k, bus.mem_req, busywait_o, k < int'(TO));
      end
    end
    drive_nop();
    @(posedge clk_i); #1;
    total++;
    if ({bus_error_o, bus.mem_req, rd_mem_wb_o} !== {1'b1, 1'b0, 5'd0}) begin
      bad++; $display("FAIL timeout_abort berr=%b req=%b rd=%0d want berr=1 req=0 rd=0",
                      bus_error_o, bus.mem_req, rd_mem_wb_o);
    end
    @(posedge clk_i); #1;
    total++;
    if (bus_error_o !== 1'b0 || busywait_o !== 1'b0 || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL timeout_idle berr=%b busy=%b req=%b want all 0", bus_error_o, busywait_o, bus.mem_req);
    end
  endtask

  task automatic test_reset_mid_access();
    wb_t e;
    drive_instr(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd6, 2'b01);
    repeat (2) @(posedge clk_i);
    #2;
    total++;
    if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b want=1", bus.mem_req); end
    rst_i = 1'b0;
    drive_nop();
    #1;
    total++;
    if (all_outs() !== {OUT_W{1'b0}}) begin
      bad++; $display("FAIL rst_mid_access got=%h want=0", all_outs());
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    drive_instr(1'b0, 1'b0, 3'b000, 32'h5, 32'h0, 5'd3, 2'b10);
    exp_q.push_back('{rd: 5'd3, alu: 32'h5, data: 32'h0, wbsel: 2'b10, ld: 1'b0});
    #1;
    total++;
    if (busywait_o !== 1'b0) begin bad++; $display("FAIL rst_add_stall got=%b want=0", busywait_o); end
    @(posedge clk_i); #1;
    drive_nop();
    e = pop_exp();
    total++;
    if (cur_wb() !== e || bus.mem_req !== 1'b0) begin
      bad++; $display("FAIL rst_add_writeback got=%h req=%b want=%h req=0", cur_wb(), bus.mem_req, e);
    end
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_load_format();
    test_store();
    test_non_memory();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
